// File: rtl/ad9833_rx_if.sv
// AD9833-style 3-wire serial bus: fsync (active low), sclk, sdata.
// The driver owns all three lines; the receiver only observes them.
interface ad9833_rx_if;
  logic fsync;
  logic sclk;
  logic sdata;

  modport master (output fsync, output sclk, output sdata);
  modport slave  (input fsync, input sclk, input sdata);
endinterface

// File: rtl/ad9833_rx.sv
// Oversampling AD9833 serial-word receiver that mirrors the DDS register file
// (control, FREQ0/1, PHASE0/1) from the words seen on the 3-wire bus.
module ad9833_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          SAMPLE_EDGE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  ad9833_rx_if.slave         bus,
  output logic [15:0]        word,
  output logic               word_valid,
  output logic [13:0]        ctrl_reg,
  output logic [27:0]        freq0,
  output logic [27:0]        freq1,
  output logic [11:0]        phase0,
  output logic [11:0]        phase1,
  output logic               frame_err
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  logic [SYNC_STAGES-1:0] fsync_sync_q, sclk_sync_q, sdata_sync_q;
  logic                   fsync_prev_q, sclk_prev_q;
  logic                   fsync_s, sclk_s, sdata_s, sample_edge;

  state_e      state_q;
  logic [3:0]  bit_cnt_q;
  logic [15:0] shift_q;
  logic        pend_q, tgt_q;
  logic [13:0] held_q;

  logic [15:0] word_asm;
  logic [13:0] payload, ctrl_d, held_d;
  logic [27:0] freq0_d, freq1_d;
  logic [11:0] phase0_d, phase1_d;
  logic        pend_d, tgt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsync_sync_q <= '1;
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      fsync_prev_q <= 1'b1;
      sclk_prev_q  <= 1'b0;
    end else begin
      fsync_sync_q <= {fsync_sync_q[SYNC_STAGES-2:0], bus.fsync};
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], bus.sdata};
      fsync_prev_q <= fsync_s;
      sclk_prev_q  <= sclk_s;
    end
  end

  assign fsync_s     = fsync_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign sdata_s     = sdata_sync_q[SYNC_STAGES-1];
  assign sample_edge = SAMPLE_EDGE ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);

  assign word_asm = {shift_q[14:0], sdata_s};
  assign payload  = word_asm[13:0];

  // Register-file next state if word_asm were committed this cycle.
  always_comb begin
    ctrl_d   = ctrl_reg;
    freq0_d  = freq0;
    freq1_d  = freq1;
    phase0_d = phase0;
    phase1_d = phase1;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    held_d   = held_q;
    case (word_asm[15:14])
      2'b00: begin
        ctrl_d = payload;
        pend_d = 1'b0;
      end
      2'b01, 2'b10: begin
        // tgt: 0 = FREQ0, 1 = FREQ1
        if (ctrl_reg[13]) begin
          if (!pend_q || (tgt_q != word_asm[15])) begin
            held_d = payload;
            pend_d = 1'b1;
            tgt_d  = word_asm[15];
          end else begin
            pend_d = 1'b0;
            if (word_asm[15]) freq1_d = {payload, held_q};
            else              freq0_d = {payload, held_q};
          end
        end else if (ctrl_reg[12]) begin
          if (word_asm[15]) freq1_d[27:14] = payload;
          else              freq0_d[27:14] = payload;
        end else begin
          if (word_asm[15]) freq1_d[13:0] = payload;
          else              freq0_d[13:0] = payload;
        end
      end
      default: begin
        if (word_asm[13]) phase1_d = word_asm[11:0];
        else              phase0_d = word_asm[11:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pend_q     <= 1'b0;
      tgt_q      <= 1'b0;
      held_q     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      ctrl_reg   <= '0;
      freq0      <= '0;
      freq1      <= '0;
      phase0     <= '0;
      phase1     <= '0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!fsync_s) state_q <= StShift;
        end
        StShift: begin
          // fsync release takes priority over a coincident sampling edge
          if (fsync_s) begin
            if (bit_cnt_q != 4'd0) frame_err <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StIdle;
          end else if (sample_edge) begin
            shift_q   <= word_asm;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              word       <= word_asm;
              word_valid <= 1'b1;
              ctrl_reg   <= ctrl_d;
              freq0      <= freq0_d;
              freq1      <= freq1_d;
              phase0     <= phase0_d;
              phase1     <= phase1_d;
              pend_q     <= pend_d;
              tgt_q      <= tgt_d;
              held_q     <= held_d;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9833_rx.sv
// Directed bench for ad9833_rx: a reference model queues the expected register
// file per word and a monitor compares it on every word_valid pulse.
module tb_ad9833_rx;

  typedef struct packed {
    logic [15:0] w;
    logic [13:0] c;
    logic [27:0] f0;
    logic [27:0] f1;
    logic [11:0] p0;
    logic [11:0] p1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic fs [2];
  logic sc [2];
  logic sd [2];

  always #5 clk = ~clk;

  ad9833_rx_if bus_r ();
  ad9833_rx_if bus_f ();
  assign bus_r.fsync = fs[0];
  assign bus_r.sclk  = sc[0];
  assign bus_r.sdata = sd[0];
  assign bus_f.fsync = fs[1];
  assign bus_f.sclk  = sc[1];
  assign bus_f.sdata = sd[1];

  logic [15:0] r_word, f_word;
  logic        r_wv, f_wv, r_fe, f_fe;
  logic [13:0] r_ctrl, f_ctrl;
  logic [27:0] r_f0, r_f1, f_f0, f_f1;
  logic [11:0] r_p0, r_p1, f_p0, f_p1;

  ad9833_rx #(.SYNC_STAGES(2), .SAMPLE_EDGE(1'b1)) u_dut_r (
    .clk(clk), .rst_n(rst_n), .bus(bus_r), .word(r_word), .word_valid(r_wv),
    .ctrl_reg(r_ctrl), .freq0(r_f0), .freq1(r_f1), .phase0(r_p0), .phase1(r_p1),
    .frame_err(r_fe)
  );

  ad9833_rx #(.SYNC_STAGES(2), .SAMPLE_EDGE(1'b0)) u_dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bus_f), .word(f_word), .word_valid(f_wv),
    .ctrl_reg(f_ctrl), .freq0(f_f0), .freq1(f_f1), .phase0(f_p0), .phase1(f_p1),
    .frame_err(f_fe)
  );

  int n_vec = 0;
  int n_err = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;
  int wvf_cnt = 0;
  exp_t sb[$];

  // Reference model state (rising-edge instance)
  logic [15:0] m_word;
  logic [13:0] m_ctrl, m_held;
  logic [27:0] m_f0, m_f1;
  logic [11:0] m_p0, m_p1;
  logic        m_pend, m_tgt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_word = '0; m_ctrl = '0; m_held = '0; m_f0 = '0; m_f1 = '0;
    m_p0 = '0; m_p1 = '0; m_pend = 1'b0; m_tgt = 1'b0;
  endtask

  task automatic model_word(input logic [15:0] w);
    logic [13:0] p;
    logic        t;
    p = w[13:0];
    t = w[15];
    if (w[15:14] == 2'b00) begin
      m_ctrl = p;
      m_pend = 1'b0;
    end else if (w[15:14] == 2'b11) begin
      if (w[13]) m_p1 = w[11:0];
      else       m_p0 = w[11:0];
    end else if (m_ctrl[13]) begin
      if (m_pend && m_tgt == t) begin
        if (t) m_f1 = {p, m_held};
        else   m_f0 = {p, m_held};
        m_pend = 1'b0;
      end else begin
        m_held = p;
        m_pend = 1'b1;
        m_tgt  = t;
      end
    end else if (m_ctrl[12]) begin
      if (t) m_f1[27:14] = p;
      else   m_f0[27:14] = p;
    end else begin
      if (t) m_f1[13:0] = p;
      else   m_f0[13:0] = p;
    end
    m_word = w;
    sb.push_back('{w: w, c: m_ctrl, f0: m_f0, f1: m_f1, p0: m_p0, p1: m_p1});
  endtask

  always @(negedge clk) begin
    if (r_wv) begin
      wv_cnt++;
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word", r_word, e.w);
        check("ctrl", r_ctrl, e.c);
        check("freq0", r_f0, e.f0);
        check("freq1", r_f1, e.f1);
        check("phase0", r_p0, e.p0);
        check("phase1", r_p1, e.p1);
      end
    end
    if (r_fe) fe_cnt++;
    if (f_wv) wvf_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 50 clk per bit: data set, half bit, active transition, half bit, back to idle
  task automatic send_bits(input int sel, input logic [15:0] w, input int n);
    logic idle;
    idle = (sel == 1);
    for (int i = 0; i < n; i++) begin
      sd[sel] = w[15-i];
      wait_clks(25);
      sc[sel] = ~idle;
      wait_clks(25);
      sc[sel] = idle;
    end
  endtask

  task automatic send_frame(input int sel, input logic [15:0] w);
    if (sel == 0) model_word(w);
    fs[sel] = 1'b0;
    wait_clks(10);
    send_bits(sel, w, 16);
    wait_clks(10);
    fs[sel] = 1'b1;
    wait_clks(20);
  endtask

  initial begin
    int wv0, fe0;
    logic [15:0] w;
    model_reset();
    rst_n = 1'b0;
    fs[0] = 1'b1; fs[1] = 1'b1;
    sc[0] = 1'b0; sc[1] = 1'b1;
    sd[0] = 1'b0; sd[1] = 1'b0;
    wait_clks(5);
    check("rst_word", r_word, 0);
    check("rst_wv", r_wv, 0);
    check("rst_ctrl", r_ctrl, 0);
    check("rst_freq0", r_f0, 0);
    check("rst_freq1", r_f1, 0);
    check("rst_phase0", r_p0, 0);
    check("rst_phase1", r_p1, 0);
    check("rst_fe", r_fe, 0);
    rst_n = 1'b1;
    wait_clks(5);

    // Three back-to-back words in one frame, B28 two-step FREQ0 load
    wv0 = wv_cnt;
    fs[0] = 1'b0;
    wait_clks(10);
    w = 16'h2000;             model_word(w); send_bits(0, w, 16);
    w = 16'h4000 | 16'h1234;  model_word(w); send_bits(0, w, 16);
    w = 16'h4000 | 16'h0ABC;  model_word(w); send_bits(0, w, 16);
    wait_clks(10);
    fs[0] = 1'b1;
    wait_clks(20);
    check("b2b_pulses", wv_cnt - wv0, 3);
    check("b28_ctrl", r_ctrl, 14'h2000);
    check("b28_freq0", r_f0, 28'h2AF1234);
    check("b28_freq1", r_f1, 0);

    // B28=0 half-word writes selected by HLB
    send_frame(0, 16'h1000);
    send_frame(0, 16'h8000 | 16'h3FFF);
    check("hlb_freq1", r_f1, 28'hFFFC000);
    send_frame(0, 16'h0000);
    send_frame(0, 16'h8000 | 16'h0001);
    check("llb_freq1", r_f1, 28'hFFFC001);

    send_frame(0, 16'hC123);
    check("phase0", r_p0, 12'h123);
    send_frame(0, 16'hF456);
    check("phase1", r_p1, 12'h456);

    // Truncated frame: 9 bits then fsync release
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    fs[0] = 1'b0;
    wait_clks(10);
    send_bits(0, 16'h5555, 9);
    wait_clks(10);
    fs[0] = 1'b1;
    wait_clks(20);
    check("trunc_fe", fe_cnt - fe0, 1);
    check("trunc_wv", wv_cnt - wv0, 0);
    check("trunc_word", r_word, m_word);
    send_frame(0, 16'hE0AA);
    check("post_trunc_p1", r_p1, 12'h0AA);

    // Reset in the middle of a FREQ0 word
    fe0 = fe_cnt;
    fs[0] = 1'b0;
    wait_clks(10);
    send_bits(0, 16'h4321, 7);
    wait_clks(3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_word", r_word, 0);
    check("mrst_ctrl", r_ctrl, 0);
    check("mrst_freq0", r_f0, 0);
    check("mrst_freq1", r_f1, 0);
    check("mrst_phase0", r_p0, 0);
    check("mrst_phase1", r_p1, 0);
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(5);
    fs[0] = 1'b1;
    wait_clks(20);
    check("mrst_fe", fe_cnt - fe0, 0);
    send_frame(0, 16'hC00F);
    check("mrst_phase0_after", r_p0, 12'h00F);

    // Falling-edge instance: B28 pending, then completion
    send_frame(1, 16'h2000);
    check("fe_ctrl", f_ctrl, 14'h2000);
    send_frame(1, 16'hA5A5);
    check("fe_word", f_word, 16'hA5A5);
    check("fe_freq0", f_f0, 0);
    check("fe_freq1", f_f1, 0);
    send_frame(1, 16'h8001);
    check("fe_freq1_done", f_f1, 28'h00065A5);
    check("fe_pulses", wvf_cnt, 3);
    check("fe_no_err", f_fe, 0);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
